// File: rtl/ddr_port1_frame_reader.sv
// ddr_port1_frame_reader
// Display-side frame fetcher. It issues MCB port-1 read bursts into a local pixel
// FIFO and serves that FIFO to the VGA stage one word per pix_rd_en. Frames are
// double-buffered: buffer 0 starts at byte 0 and buffer 1 at BASE1.
// Optional feature: define UNDERFLOW_CNT_EN to build the saturating underflow
// counter. Without it, underflow_count is tied to zero.
//
// Handshakes (strict): p1_cmd_en is a one-cycle strobe, issued only after
// p1_cmd_full was seen low in WAIT. A read word transfers on a cycle where
// p1_rd_en && !p1_rd_empty. A pixel pops on pix_rd_en while the FIFO is
// non-empty, and pix_data carries that word on the following cycle.
module ddr_port1_frame_reader #(
  parameter int BURST_LEN   = 32,
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_DEPTH  = 128,
  parameter int BASE1       = 1228800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic        frame_start,
  input  logic        rd_frame,
  output logic        p1_cmd_en,
  output logic [2:0]  p1_cmd_instr,
  output logic [5:0]  p1_cmd_bl,
  output logic [29:0] p1_cmd_byte_addr,
  input  logic        p1_cmd_full,
  output logic        p1_rd_en,
  input  logic        p1_rd_empty,
  input  logic [31:0] p1_rd_data,
  input  logic        pix_rd_en,
  output logic [31:0] pix_data,
  output logic        pix_empty,
  output logic        frame_done,
  output logic [15:0] underflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {ST_INIT, ST_WAIT, ST_ISSUE, ST_DRAIN} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_calib_meta;
  logic            r_calib_sync;
  logic [29:0]     r_pointer;
  logic [WW-1:0]   r_words;
  logic [BW-1:0]   r_beat;
  logic            r_restart_pend;
  logic            r_pend_frame;
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [31:0]     r_pix_data;
  logic            r_pix_empty;

  logic [AW:0]     w_occ;
  logic [AW+1:0]   w_free;
  logic            w_fifo_empty;
  logic            w_accept;
  logic            w_last_beat;
  logic            w_discard;
  logic            w_push;
  logic            w_pop;
  logic            w_restart;
  logic            w_restart_sel;
  logic            w_frame_full;
  logic [AW:0]     w_wr_next;
  logic [AW:0]     w_rd_next;

  // FIFO bookkeeping and burst/restart decode
  assign w_occ         = r_wr_ptr - r_rd_ptr;
  assign w_free        = (AW+2)'(FIFO_DEPTH) - {1'b0, w_occ};
  assign w_fifo_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_accept      = (r_state == ST_DRAIN) && !p1_rd_empty;
  assign w_last_beat   = w_accept && (r_beat == BW'(BURST_LEN - 1));
  // Words of a burst that overlaps a frame_start are stale and get dropped
  assign w_discard     = r_restart_pend | frame_start;
  assign w_push        = w_accept && !w_discard;
  assign w_pop         = pix_rd_en && !w_fifo_empty;
  assign w_restart     = ((r_state == ST_WAIT) && frame_start) || (w_last_beat && w_discard);
  assign w_restart_sel = frame_start ? rd_frame : r_pend_frame;
  assign w_frame_full  = (r_words == WW'(FRAME_WORDS));
  assign w_wr_next     = w_restart ? '0 : (w_push ? r_wr_ptr + (AW+1)'(1) : r_wr_ptr);
  assign w_rd_next     = w_restart ? '0 : (w_pop  ? r_rd_ptr + (AW+1)'(1) : r_rd_ptr);

  assign p1_cmd_en        = (r_state == ST_ISSUE);
  assign p1_cmd_instr     = 3'b001;
  assign p1_cmd_bl        = 6'(BURST_LEN - 1);
  assign p1_cmd_byte_addr = r_pointer;
  assign p1_rd_en         = w_accept;
  assign pix_data         = r_pix_data;
  assign pix_empty        = r_pix_empty;
  assign frame_done       = (r_state == ST_WAIT) && w_frame_full;

  // Two-flop synchroniser for the asynchronous calibration flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_calib_meta <= 1'b0;
      r_calib_sync <= 1'b0;
    end else begin
      r_calib_meta <= mem_calib_done;
      r_calib_sync <= r_calib_meta;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_next_state;
  end

  // FSM next-state: a frame_start in WAIT keeps us in WAIT for the restart
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT:  if (r_calib_sync) w_next_state = ST_WAIT;
      ST_WAIT:  if (!frame_start && !w_frame_full && !p1_cmd_full &&
                    (w_free >= (AW+2)'(BURST_LEN))) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_last_beat) w_next_state = ST_WAIT;
      default:  w_next_state = ST_INIT;
    endcase
  end

  // Address pointer, fetched-word count, beat counter and pending restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pointer      <= '0;
      r_words        <= '0;
      r_beat         <= '0;
      r_restart_pend <= 1'b0;
      r_pend_frame   <= 1'b0;
    end else begin
      if (w_last_beat)   r_beat <= '0;
      else if (w_accept) r_beat <= r_beat + BW'(1);
      if (w_restart) begin
        r_pointer      <= w_restart_sel ? 30'(BASE1) : 30'd0;
        r_words        <= '0;
        r_restart_pend <= 1'b0;
      end else begin
        if (r_state == ST_ISSUE) r_pointer <= r_pointer + 30'(BURST_LEN * 4);
        if (w_last_beat)         r_words   <= r_words + WW'(BURST_LEN);
        if (frame_start && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN))) begin
          r_restart_pend <= 1'b1;
          r_pend_frame   <= rd_frame;
        end
      end
    end
  end

  // Pixel FIFO pointers, registered read data and registered empty flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pix_data  <= '0;
      r_pix_empty <= 1'b1;
    end else begin
      r_wr_ptr    <= w_wr_next;
      r_rd_ptr    <= w_rd_next;
      r_pix_empty <= (w_wr_next == w_rd_next);
      if (w_pop) r_pix_data <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  // Pixel FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= p1_rd_data;
  end

`ifdef UNDERFLOW_CNT_EN
  logic [15:0] r_underflow;

  // Saturating count of pops requested while the FIFO is empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_underflow <= '0;
    else if (pix_rd_en && w_fifo_empty && (r_underflow != 16'hFFFF))
      r_underflow <= r_underflow + 16'd1;
  end

  assign underflow_count = r_underflow;
`else
  assign underflow_count = 16'd0;
`endif

endmodule

// File: tb/tb_ddr_port1_frame_reader.sv
// tb_ddr_port1_frame_reader
// Small configuration: BURST_LEN=4, FRAME_WORDS=16, FIFO_DEPTH=8, BASE1=64.
// An MCB read model returns word (byte_addr/4 + i) two cycles after each command.
// A frame-level model keeps the expected pixel words in a queue and is compared
// with the DUT on every falling edge. Directed phases add literal checks.
module tb_ddr_port1_frame_reader;

  localparam int BL = 4;
  localparam int FW = 16;
  localparam int FD = 8;
  localparam int B1 = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_calib_done;
  logic        frame_start;
  logic        rd_frame;
  logic        p1_cmd_en;
  logic [2:0]  p1_cmd_instr;
  logic [5:0]  p1_cmd_bl;
  logic [29:0] p1_cmd_byte_addr;
  logic        p1_cmd_full;
  logic        p1_rd_en;
  logic        p1_rd_empty;
  logic [31:0] p1_rd_data;
  logic        pix_rd_en;
  logic [31:0] pix_data;
  logic        pix_empty;
  logic        frame_done;
  logic [15:0] underflow_count;

  ddr_port1_frame_reader #(
    .BURST_LEN(BL), .FRAME_WORDS(FW), .FIFO_DEPTH(FD), .BASE1(B1)
  ) dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
    .frame_start(frame_start), .rd_frame(rd_frame),
    .p1_cmd_en(p1_cmd_en), .p1_cmd_instr(p1_cmd_instr), .p1_cmd_bl(p1_cmd_bl),
    .p1_cmd_byte_addr(p1_cmd_byte_addr), .p1_cmd_full(p1_cmd_full),
    .p1_rd_en(p1_rd_en), .p1_rd_empty(p1_rd_empty), .p1_rd_data(p1_rd_data),
    .pix_rd_en(pix_rd_en), .pix_data(pix_data), .pix_empty(pix_empty),
    .frame_done(frame_done), .underflow_count(underflow_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- MCB port-1 read model ----------------
  logic [31:0] mcb_data_q[$];
  int          mcb_rdy_q[$];
  int          cyc = 0;
  logic        c_cmd, c_rd;
  logic [29:0] c_addr;

  always begin
    @(negedge clk);
    c_cmd  = p1_cmd_en;
    c_addr = p1_cmd_byte_addr;
    c_rd   = p1_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      mcb_data_q.delete();
      mcb_rdy_q.delete();
    end else begin
      if (c_rd && (mcb_data_q.size() > 0)) begin
        void'(mcb_data_q.pop_front());
        void'(mcb_rdy_q.pop_front());
      end
      if (c_cmd) begin
        for (int i = 0; i < BL; i++) begin
          mcb_data_q.push_back(32'(c_addr >> 2) + 32'(i));
          mcb_rdy_q.push_back(cyc + 2);
        end
      end
    end
    if ((mcb_data_q.size() > 0) && (mcb_rdy_q[0] <= cyc)) begin
      p1_rd_empty = 1'b0;
      p1_rd_data  = mcb_data_q[0];
    end else begin
      p1_rd_empty = 1'b1;
      p1_rd_data  = 32'd0;
    end
  end

  // ---------------- frame-level model + scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] pop_log[$];
  logic [29:0] cmd_log[$];
  int          burst_left = 0;
  bit          burst_discard = 0;
  bit          pend = 0;
  logic [29:0] next_addr = '0;
  int          kept = 0;
  logic [31:0] exp_pd = '0;
  bit          exp_pe = 1'b1;
  bit          exp_fd = 1'b0;
  logic [15:0] exp_uf = '0;

  always @(negedge clk) begin
    chk("pix_data",   pix_data, exp_pd);
    chk("pix_empty",  32'(pix_empty), 32'(exp_pe));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    chk("underflow",  32'(underflow_count), 32'(exp_uf));
    chk("cmd_instr",  32'(p1_cmd_instr), 32'd1);
    chk("cmd_bl",     32'(p1_cmd_bl), 32'(BL - 1));
    if (reset) begin
      chk("rst_cmd_en", 32'(p1_cmd_en), 32'd0);
      chk("rst_rd_en",  32'(p1_rd_en), 32'd0);
      exp_q.delete();
      burst_left = 0; burst_discard = 0; pend = 0;
      next_addr = '0; kept = 0;
      exp_pd = '0; exp_pe = 1'b1; exp_fd = 1'b0; exp_uf = '0;
    end else begin
      if (p1_cmd_en) begin
        chk("cmd_addr", 32'(p1_cmd_byte_addr), 32'(next_addr));
        chk("cmd_while_busy", 32'(burst_left), 32'd0);
        chk("cmd_after_done", 32'(kept < FW), 32'd1);
        cmd_log.push_back(p1_cmd_byte_addr);
        next_addr     = next_addr + 30'(BL * 4);
        burst_left    = BL;
        burst_discard = 1'b0;
      end
      if (pix_rd_en) begin
        if (exp_q.size() > 0) begin
          exp_pd = exp_q.pop_front();
          pop_log.push_back(exp_pd);
        end else begin
`ifdef UNDERFLOW_CNT_EN
          if (exp_uf != 16'hFFFF) exp_uf = exp_uf + 16'd1;
`endif
        end
      end
      if (frame_start) begin
        next_addr = rd_frame ? 30'(B1) : 30'd0;
        if (burst_left > 0) begin
          pend          = 1'b1;
          burst_discard = 1'b1;
        end else begin
          exp_q.delete();
          kept = 0;
        end
      end
      if (p1_rd_en) begin
        chk("rd_en_in_burst", 32'(burst_left > 0), 32'd1);
        if (burst_left > 0) begin
          burst_left--;
          if (!burst_discard) begin
            exp_q.push_back(p1_rd_data);
            kept++;
          end
          if ((burst_left == 0) && pend) begin
            exp_q.delete();
            kept = 0;
            pend = 1'b0;
          end
        end
      end
      exp_pe = (exp_q.size() == 0);
      exp_fd = (kept == FW);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pop n words, only on cycles where the FIFO reports data
  task automatic pop_words(input int n);
    int got = 0;
    int guard = 0;
    while ((got < n) && (guard < 400)) begin
      if (!pix_empty) begin
        pix_rd_en = 1'b1;
        got++;
      end else begin
        pix_rd_en = 1'b0;
      end
      tick(1);
      guard++;
    end
    pix_rd_en = 1'b0;
    if (got < n) chk("pop_timeout", 32'(got), 32'(n));
  endtask

  task automatic pulse_frame_start(input logic sel);
    frame_start = 1'b1;
    rd_frame    = sel;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_cmds(input int n, input string name);
    int guard = 0;
    while ((cmd_log.size() < n) && (guard < 100)) begin
      tick(1);
      guard++;
    end
    if (cmd_log.size() < n) chk(name, 32'(cmd_log.size()), 32'(n));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; mem_calib_done = 1'b0; frame_start = 1'b0; rd_frame = 1'b0;
    p1_cmd_full = 1'b0; pix_rd_en = 1'b0; p1_rd_empty = 1'b1; p1_rd_data = '0;
    tick(3);
    reset = 1'b0;
    mem_calib_done = 1'b1;

    // No pops: FIFO of 8 holds two bursts, then fetch stalls
    tick(40);
    chk("a_two_bursts", 32'(cmd_log.size()), 32'd2);
    chk("a_not_empty", 32'(pix_empty), 32'd0);
    pop_words(1);
    tick(20);
    chk("a_one_pop_no_issue", 32'(cmd_log.size()), 32'd2);
    pop_words(3);
    tick(20);
    chk("a_third_burst", 32'(cmd_log.size()), 32'd3);

    // Drain the whole frame 0
    pop_words(12);
    tick(20);
    chk("b_frame_done", 32'(frame_done), 32'd1);
    chk("b_cmd_count", 32'(cmd_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("b_cmd_addr", 32'(cmd_log[i]), 32'(i * 16));
    chk("b_pop_count", 32'(pop_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("b_pixel", pop_log[i], 32'(i));
    chk("b_pix_empty", 32'(pix_empty), 32'd1);

    // Three pops on an empty FIFO
    pix_rd_en = 1'b1;
    tick(3);
    pix_rd_en = 1'b0;
    tick(2);
`ifdef UNDERFLOW_CNT_EN
    chk("c_underflow", 32'(underflow_count), 32'd3);
`else
    chk("c_underflow", 32'(underflow_count), 32'd0);
`endif
    chk("c_pix_hold", pix_data, 32'd15);

    // Restart to buffer 0 with the command FIFO full
    p1_cmd_full = 1'b1;
    pulse_frame_start(1'b0);
    tick(10);
    chk("d_full_blocks", 32'(cmd_log.size()), 32'd4);
    chk("d_frame_done_clr", 32'(frame_done), 32'd0);
    p1_cmd_full = 1'b0;
    tick(2);
    chk("d_issue_after_release", 32'(cmd_log.size()), 32'd5);
    chk("d_addr0", 32'(cmd_log[4]), 32'd0);

    // Two frame_starts mid-DRAIN of the second burst; the later rd_frame wins
    wait_cmds(6, "e_second_cmd_timeout");
    begin
      int guard = 0;
      @(negedge clk);
      while (!p1_rd_en && (guard < 40)) begin
        @(negedge clk);
        guard++;
      end
      if (!p1_rd_en) chk("e_drain_timeout", 32'(p1_rd_en), 32'd1);
    end
    @(posedge clk);
    #1;
    frame_start = 1'b1; rd_frame = 1'b0;
    tick(1);
    rd_frame = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(3);
    chk("e_flushed_empty", 32'(pix_empty), 32'd1);
    wait_cmds(7, "e_restart_cmd_timeout");
    chk("e_base1_addr", 32'(cmd_log.size() > 6 ? cmd_log[6] : 30'h3FFFFFFF), 32'd64);
    pop_words(16);
    tick(20);
    chk("e_frame_done", 32'(frame_done), 32'd1);
    chk("e_pop_count", 32'(pop_log.size()), 32'd32);
    for (int i = 16; i < 32; i++) chk("e_pixel", pop_log[i], 32'(i));
    chk("e_cmd_count", 32'(cmd_log.size()), 32'd10);
    chk("e_last_addr", 32'(cmd_log.size() > 9 ? cmd_log[9] : 30'h3FFFFFFF), 32'd112);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
